axis_sample_packer: RTL and testbench

- Packs a continuous stream of ADC/servo samples (one per axis_clk when sample_valid) into BUS_WIDTH-wide AXI-stream words.
- Sits directly upstream of axis_sync_fifo and drives its s_axis_* input; the FIFO's output goes to the capture/DMA path.
- Provides programmable decimation, a start/stop enable, and a saturating drop counter for words lost to FIFO backpressure.

---
 rtl/axis_sample_packer_pkg.sv | 16 +
 rtl/axis_sample_packer_if.sv | 13 +
 rtl/axis_sample_packer_hold_reg.sv | 34 +++
 rtl/axis_sample_packer.sv | 132 +++++++++++++
 tb/tb_axis_sample_packer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_sample_packer_pkg.sv
// Shared types and helpers for the AXI-stream sample packer and its output hold register.
package axis_sample_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int DROP_CNT_WIDTH = 32;

  function automatic int lanes(input int bus_width, input int sample_width);
    return bus_width / sample_width;
  endfunction

endpackage

// File: rtl/axis_sample_packer_if.sv
// AXI-stream word channel between the sample packer and the downstream FIFO.
interface axis_sample_packer_if #(
  parameter int BUS_WIDTH = 256
);

  logic [BUS_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_sample_packer_hold_reg.sv
// axis_hold_reg: single-entry AXI-stream output register that reports load, accept and overflow.
module axis_hold_reg #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] tdata,
  output logic             tvalid,
  input  logic             tready,
  output logic             load_ok,
  output logic             accept,
  output logic             overflow
);

  // A new word may replace the held one in the same cycle it is consumed.
  assign accept   = tvalid & tready;
  assign load_ok  = load & (~tvalid | accept);
  assign overflow = load & ~load_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tdata  <= '0;
      tvalid <= 1'b0;
    end else if (load_ok) begin
      tdata  <= load_data;
      tvalid <= 1'b1;
    end else if (accept) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_sample_packer.sv
// Packs decimated samples into wide AXI-stream words and counts words lost to backpressure.
// Optional macro AXIS_SAMPLE_PACKER_SEQ_TAG_EN puts a word sequence number in lane 0.
module axis_sample_packer
  import axis_sample_packer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BUS_WIDTH    = 256,
  parameter int DECIM_WIDTH  = 16
) (
  input  logic                      axis_clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [DECIM_WIDTH-1:0]    decim,
  input  logic [SAMPLE_WIDTH-1:0]   sample_in,
  input  logic                      sample_valid,
  axis_sample_packer_if.master      m_axis,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      busy
);

  localparam int LANES = lanes(BUS_WIDTH, SAMPLE_WIDTH);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
`ifdef AXIS_SAMPLE_PACKER_SEQ_TAG_EN
  localparam int FIRST_LANE = 1;
`else
  localparam int FIRST_LANE = 0;
`endif
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_LANE);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LANES - 1);

  state_t                 state;
  state_t                 state_next;
  logic [DECIM_WIDTH-1:0] decim_q;
  logic [DECIM_WIDTH-1:0] dcnt;
  logic [IDX_W-1:0]       idx;
  logic [BUS_WIDTH-1:0]   acc;
  logic [BUS_WIDTH-1:0]   word;
  logic                   keep;
  logic                   complete;
  logic                   load_ok;
  logic                   accept;
  logic                   overflow;
  logic                   hold_full_next;
`ifdef AXIS_SAMPLE_PACKER_SEQ_TAG_EN
  logic [SAMPLE_WIDTH-1:0] seq;
`endif

  assign keep     = (state == RUN) && sample_valid && (dcnt == '0);
  assign complete = keep && (idx == LAST_IDX);
  assign busy     = (state != IDLE);
  assign hold_full_next = load_ok | (m_axis.tvalid & ~accept);

  always_comb begin
    word = acc;
    word[int'(idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_in;
`ifdef AXIS_SAMPLE_PACKER_SEQ_TAG_EN
    word[SAMPLE_WIDTH-1:0] = seq;
`endif
  end

  // Leaving RUN must wait in DRAIN while a word is still held, including one completed this cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = hold_full_next ? DRAIN : IDLE;
      DRAIN:   if (!hold_full_next) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!rst) begin
      state   <= IDLE;
      decim_q <= '0;
      dcnt    <= '0;
      idx     <= '0;
      acc     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && enable) begin
        decim_q <= decim;
        dcnt    <= '0;
        idx     <= FIRST_IDX;
      end else if (state == RUN) begin
        if (sample_valid)
          dcnt <= (dcnt == '0) ? decim_q : dcnt - DECIM_WIDTH'(1);
        if (!enable)
          idx <= FIRST_IDX;
        else if (keep)
          idx <= complete ? FIRST_IDX : idx + IDX_W'(1);
        if (keep && !complete)
          acc[int'(idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= sample_in;
      end
    end
  end

`ifdef AXIS_SAMPLE_PACKER_SEQ_TAG_EN
  // Dropped words still consume a sequence number so downstream can see the gap.
  always_ff @(posedge axis_clk) begin
    if (!rst)
      seq <= '0;
    else if (state == IDLE && enable)
      seq <= '0;
    else if (complete)
      seq <= seq + SAMPLE_WIDTH'(1);
  end
`endif

  always_ff @(posedge axis_clk) begin
    if (!rst)
      drop_count <= '0;
    else if (overflow && drop_count != '1)
      drop_count <= drop_count + DROP_CNT_WIDTH'(1);
  end

  axis_hold_reg #(
    .WIDTH(BUS_WIDTH)
  ) u_hold (
    .clk      (axis_clk),
    .rst      (rst),
    .load     (complete),
    .load_data(word),
    .tdata    (m_axis.tdata),
    .tvalid   (m_axis.tvalid),
    .tready   (m_axis.tready),
    .load_ok  (load_ok),
    .accept   (accept),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_axis_sample_packer.sv
// Self-checking bench for axis_sample_packer against a queue-based behavioural model.
// Honours AXIS_SAMPLE_PACKER_SEQ_TAG_EN when defined for the build.
module tb_axis_sample_packer;

  localparam int SW    = 16;
  localparam int BW    = 256;
  localparam int LANES = BW / SW;
`ifdef AXIS_SAMPLE_PACKER_SEQ_TAG_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int PER_WORD = LANES - FIRST;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   decim = '0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic [31:0]   drop_count;
  logic          busy;

  axis_sample_packer_if #(.BUS_WIDTH(BW)) m_axis ();

  axis_sample_packer #(
    .SAMPLE_WIDTH(SW),
    .BUS_WIDTH   (BW),
    .DECIM_WIDTH (16)
  ) dut (
    .axis_clk    (clk),
    .rst         (rst),
    .enable      (enable),
    .decim       (decim),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .m_axis      (m_axis),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_accepts = 0;

  // Behavioural model: mode 0 idle, 1 capturing, 2 draining
  int            m_mode = 0;
  int            m_n = 0;
  int            m_decim = 0;
  int            m_seq = 0;
  int            m_accepts = 0;
  logic [SW-1:0] m_samples[$];
  logic          m_hv = 1'b0;
  logic [BW-1:0] m_hw = '0;
  logic [31:0]   m_drops = '0;

  function automatic logic [BW-1:0] pack();
    logic [BW-1:0] w;
    w = '0;
    for (int i = 0; i < PER_WORD; i++) w[(FIRST+i)*SW +: SW] = m_samples[i];
`ifdef AXIS_SAMPLE_PACKER_SEQ_TAG_EN
    w[SW-1:0] = m_seq[SW-1:0];
`endif
    return w;
  endfunction

  function automatic void model_edge(input logic en, input logic sv, input logic [SW-1:0] s,
                                     input logic rdy);
    if (!rst) begin
      m_mode = 0; m_hv = 1'b0; m_hw = '0; m_drops = '0; m_samples.delete();
      return;
    end
    if (m_hv && rdy) begin
      m_hv = 1'b0;
      m_accepts++;
    end
    case (m_mode)
      0: if (en) begin
        m_mode = 1; m_decim = int'(decim); m_n = 0; m_seq = 0; m_samples.delete();
      end
      1: begin
        if (sv) begin
          if (m_n % (m_decim + 1) == 0) m_samples.push_back(s);
          m_n++;
          if (m_samples.size() == PER_WORD) begin
            if (!m_hv) begin
              m_hv = 1'b1;
              m_hw = pack();
            end else if (m_drops != 32'hFFFF_FFFF) begin
              m_drops++;
            end
            m_samples.delete();
            m_seq++;
          end
        end
        if (!en) begin
          m_samples.delete();
          m_mode = m_hv ? 2 : 0;
        end
      end
      default: if (!m_hv) m_mode = 0;
    endcase
  endfunction

  task automatic step(input logic en, input logic sv, input logic [SW-1:0] s, input logic rdy);
    enable = en; sample_valid = sv; sample_in = s; m_axis.tready = rdy;
    if (m_axis.tvalid === 1'b1 && rdy) dut_accepts++;
    @(posedge clk);
    model_edge(en, sv, s, rdy);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    checks += 4;
    if (m_axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid actual %b required 0", m_axis.tvalid); end
    if (m_axis.tdata !== '0) begin errors++; $display("[TB] FAIL reset_tdata actual %h required 0", m_axis.tdata); end
    if (drop_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_drop actual %0d required 0", drop_count); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy actual %b required 0", busy); end
    rst = 1'b1;
    step(0, 0, '0, 1);
  endtask

  task automatic test_basic();
    int a0;
    a0 = dut_accepts;
    decim = 16'd0;
    step(1, 0, '0, 1);
    for (int i = 0; i < 2 * PER_WORD + 3; i++) begin
      if (i < 2 * PER_WORD) step(1, 1, SW'(i), 1); else step(1, 0, '0, 1);
      checks++;
      if (m_axis.tvalid !== m_hv) begin errors++; $display("[TB] FAIL basic_tvalid cyc %0d actual %b required %b", i, m_axis.tvalid, m_hv); end
      if (m_hv) begin
        checks++;
        if (m_axis.tdata !== m_hw) begin errors++; $display("[TB] FAIL basic_tdata cyc %0d actual %h required %h", i, m_axis.tdata, m_hw); end
      end
      if (i == PER_WORD - 1 || i == 2 * PER_WORD - 1) begin
        checks++;
        if (m_axis.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency cyc %0d actual %b required 1", i, m_axis.tvalid); end
      end
    end
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    checks += 3;
    if (dut_accepts - a0 != 2) begin errors++; $display("[TB] FAIL basic_words actual %0d required 2", dut_accepts - a0); end
    if (drop_count !== 32'd0) begin errors++; $display("[TB] FAIL basic_drop actual %0d required 0", drop_count); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy actual %b required 0", busy); end
  endtask

  task automatic test_decim();
    int a0;
    a0 = dut_accepts;
    decim = 16'd3;
    step(1, 0, '0, 1);
    decim = 16'd0;
    for (int i = 0; i < 66; i++) begin
      if (i < 64) step(1, 1, SW'(i), 1); else step(1, 0, '0, 1);
      checks++;
      if (m_axis.tvalid !== m_hv) begin errors++; $display("[TB] FAIL decim_tvalid cyc %0d actual %b required %b", i, m_axis.tvalid, m_hv); end
      if (m_hv) begin
        checks++;
        if (m_axis.tdata !== m_hw) begin errors++; $display("[TB] FAIL decim_tdata cyc %0d actual %h required %h", i, m_axis.tdata, m_hw); end
      end
    end
    step(0, 0, '0, 1);
    checks++;
    if (dut_accepts - a0 != 1) begin errors++; $display("[TB] FAIL decim_words actual %0d required 1", dut_accepts - a0); end
  endtask

  task automatic test_backpressure();
    decim = 16'd0;
    step(1, 0, '0, 0);
    for (int i = 0; i < 48; i++) begin
      step(1, 1, SW'(100 + i), 0);
      checks++;
      if (m_axis.tvalid !== m_hv) begin errors++; $display("[TB] FAIL bp_tvalid cyc %0d actual %b required %b", i, m_axis.tvalid, m_hv); end
      if (m_hv) begin
        checks++;
        if (m_axis.tdata !== m_hw) begin errors++; $display("[TB] FAIL bp_tdata cyc %0d actual %h required %h", i, m_axis.tdata, m_hw); end
      end
    end
    checks += 2;
    if (drop_count !== 32'd2) begin errors++; $display("[TB] FAIL bp_drop actual %0d required 2", drop_count); end
    if (drop_count !== m_drops) begin errors++; $display("[TB] FAIL bp_drop_model actual %0d required %0d", drop_count, m_drops); end
    step(1, 0, '0, 1);
    checks++;
    if (m_axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release actual %b required 0", m_axis.tvalid); end
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
  endtask

  task automatic test_disable_partial();
    int a0;
    decim = 16'd0;
    step(1, 0, '0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, SW'(200 + i), 1);
    step(0, 1, SW'(205), 1);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL partial_busy actual %b required 0", busy); end
    if (m_axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL partial_tvalid actual %b required 0", m_axis.tvalid); end
    a0 = dut_accepts;
    step(1, 0, '0, 1);
    for (int i = 0; i < PER_WORD + 1; i++) begin
      if (i < PER_WORD) step(1, 1, SW'(300 + i), 1); else step(1, 0, '0, 1);
      checks++;
      if (m_axis.tvalid !== m_hv) begin errors++; $display("[TB] FAIL partial_tvalid2 cyc %0d actual %b required %b", i, m_axis.tvalid, m_hv); end
      if (m_hv) begin
        checks++;
        if (m_axis.tdata !== m_hw) begin errors++; $display("[TB] FAIL partial_tdata cyc %0d actual %h required %h", i, m_axis.tdata, m_hw); end
      end
    end
    step(0, 0, '0, 1);
    checks++;
    if (dut_accepts - a0 != 1) begin errors++; $display("[TB] FAIL partial_words actual %0d required 1", dut_accepts - a0); end
  endtask

  task automatic test_reset_mid();
    decim = 16'd0;
    step(1, 0, '0, 0);
    for (int i = 0; i < 2 * PER_WORD; i++) step(1, 1, SW'(400 + i), 0);
    checks++;
    if (m_axis.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre_tvalid actual %b required 1", m_axis.tvalid); end
    rst = 1'b0;
    step(1, 0, '0, 0);
    rst = 1'b1;
    checks += 3;
    if (m_axis.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_tvalid actual %b required 0", m_axis.tvalid); end
    if (drop_count !== 32'd0) begin errors++; $display("[TB] FAIL rmid_drop actual %0d required 0", drop_count); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy actual %b required 0", busy); end
    step(1, 0, '0, 1);
    for (int i = 0; i < PER_WORD + 1; i++) begin
      if (i < PER_WORD) step(1, 1, SW'(500 + i), 1); else step(1, 0, '0, 1);
      if (m_hv) begin
        checks++;
        if (m_axis.tdata !== m_hw) begin errors++; $display("[TB] FAIL rmid_tdata cyc %0d actual %h required %h", i, m_axis.tdata, m_hw); end
      end
    end
    step(0, 0, '0, 1);
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = dut_accepts;
    decim = 16'd0;
    step(1, 0, '0, 1);
    for (int i = 0; i < 5 * PER_WORD; i++) begin
      step(1, 1, SW'($urandom), 1);
      checks++;
      if (m_axis.tvalid !== m_hv) begin errors++; $display("[TB] FAIL b2b_tvalid cyc %0d actual %b required %b", i, m_axis.tvalid, m_hv); end
      if (m_hv) begin
        checks++;
        if (m_axis.tdata !== m_hw) begin errors++; $display("[TB] FAIL b2b_tdata cyc %0d actual %h required %h", i, m_axis.tdata, m_hw); end
      end
    end
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    checks += 2;
    if (dut_accepts - a0 != 5) begin errors++; $display("[TB] FAIL b2b_words actual %0d required 5", dut_accepts - a0); end
    if (drop_count !== 32'd0) begin errors++; $display("[TB] FAIL b2b_drop actual %0d required 0", drop_count); end
  endtask

  task automatic test_random();
    logic en;
    for (int i = 0; i < 800; i++) begin
      decim = 16'($urandom_range(0, 2));
      en = ($urandom_range(0, 59) != 0);
      step(en, ($urandom_range(0, 3) != 0), SW'($urandom), ($urandom_range(0, 4) < 3));
      checks += 3;
      if (m_axis.tvalid !== m_hv) begin errors++; $display("[TB] FAIL rnd_tvalid cyc %0d actual %b required %b", i, m_axis.tvalid, m_hv); end
      if (drop_count !== m_drops) begin errors++; $display("[TB] FAIL rnd_drop cyc %0d actual %0d required %0d", i, drop_count, m_drops); end
      if (busy !== (m_mode != 0)) begin errors++; $display("[TB] FAIL rnd_busy cyc %0d actual %b required %b", i, busy, (m_mode != 0)); end
      if (m_hv) begin
        checks++;
        if (m_axis.tdata !== m_hw) begin errors++; $display("[TB] FAIL rnd_tdata cyc %0d actual %h required %h", i, m_axis.tdata, m_hw); end
      end
    end
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    checks++;
    if (dut_accepts != m_accepts) begin errors++; $display("[TB] FAIL rnd_words actual %0d required %0d", dut_accepts, m_accepts); end
  endtask

  initial begin
    m_axis.tready = 1'b0;
    test_reset();
    test_basic();
    test_decim();
    test_backpressure();
    test_disable_partial();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
